// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// FSM state encoding and access-size decoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Unknown funct3 codes fall back to word size so they get word alignment.
    function automatic lsu_size_e size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_of = SZ_B;
            F3_H, F3_HU: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = lo[0];
            default: is_misaligned = |lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lo,
    input  logic [2:0]  f3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension of the read word.
    always_comb begin
        shifted  = rdata >> {lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = lo[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store control into a
// request/ready bus transaction, stalls while it is outstanding, formats
// load data, and flags misaligned accesses and bus timeouts.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Alu_Result,
    input  logic [31:0] Store_Data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] MemReadData,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  lo_q, lo_d;
    logic [2:0]  f3_q, f3_d;

    logic        access;
    logic        bad_addr;
    lsu_size_e   sz;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] load_data;

    // The captured byte offset and funct3 format the word returned in WAIT.
    load_align u_align (
        .rdata (mem_rdata),
        .lo    (lo_q),
        .f3    (f3_q),
        .data  (load_data)
    );

    // Access decode and store lane replication / byte strobes.
    always_comb begin
        access   = MemRead | MemWrite;
        sz       = size_of(funct3);
        bad_addr = is_misaligned(sz, Alu_Result[1:0]);
        case (sz)
            SZ_B: begin
                lane_wdata = {4{Store_Data[7:0]}};
                lane_wstrb = 4'b0001 << Alu_Result[1:0];
            end
            SZ_H: begin
                lane_wdata = {2{Store_Data[15:0]}};
                lane_wstrb = 4'b0011 << Alu_Result[1:0];
            end
            default: begin
                lane_wdata = Store_Data;
                lane_wstrb = 4'b1111;
            end
        endcase
        if (!MemWrite) begin
            lane_wstrb = 4'b0000;
        end
    end

    // Transaction FSM next-state and registered bus/result outputs.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        f3_d    = f3_q;
        case (state_q)
            ST_IDLE: begin
                if (access && !bad_addr) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = {Alu_Result[31:2], 2'b00};
                    wdata_d = lane_wdata;
                    wstrb_d = lane_wstrb;
                    cnt_d   = 16'h0;
                    lo_d    = Alu_Result[1:0];
                    f3_d    = funct3;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rd_d = load_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rd_d    = 32'h0;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with immediate asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rd_q    <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= 16'h0;
            lo_q    <= 2'b00;
            f3_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            f3_q    <= f3_d;
        end
    end

    // Stall covers the launch cycle and every WAIT cycle; DONE lets the pipeline advance.
    always_comb begin
        misaligned  = (state_q == ST_IDLE) && access && bad_addr;
        stall       = ((state_q == ST_IDLE) && access && !bad_addr) || (state_q == ST_WAIT);
        mem_req     = req_q;
        mem_we      = we_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        mem_wstrb   = wstrb_q;
        MemReadData = rd_q;
        bus_err     = err_q;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized and directed bench for mem_stage_lsu against a behavioural model.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] Alu_Result = 32'h0;
    logic [31:0] Store_Data = 32'h0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] MemReadData;
    logic        stall, misaligned, bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_rd = 32'h0;

    mem_stage_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .Alu_Result(Alu_Result), .Store_Data(Store_Data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .MemReadData(MemReadData), .stall(stall),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic int sz_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
        int n = sz_bytes(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = sz_bytes(f3);
        logic [31:0] r = 32'h0;
        if (n == 4) return d;
        for (int k = 0; k < 4 / n; k++)
            r = r | ((d & ((32'h1 << (8 * n)) - 1)) << (8 * n * k));
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] sh = rd >> (8 * (a % 4));
        int v;
        case (f3)
            3'd0, 3'd4: begin
                v = int'(sh & 32'hFF);
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = int'(sh & 32'hFFFF);
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: return rd;
        endcase
        return 32'(v);
    endfunction

    // ---------------- one load/store transaction ----------------
    task automatic do_txn(input string nm, input logic mr, input logic mw,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int waits);
        logic is_st    = mw;
        logic bad      = (a % sz_bytes(f3)) != 0;
        logic tmo      = waits >= TO;
        int   exp_wait = tmo ? TO : waits + 1;
        logic [3:0]  e_strb  = is_st ? exp_strb(f3, a) : 4'h0;
        logic [31:0] e_wdata = exp_wdata(f3, sd);
        int   stall_cnt = 0;
        int   wait_cyc  = 0;
        logic done_seen = 1'b0;
        logic [31:0] e_rd;

        @(posedge clk); #1;
        MemRead = mr; MemWrite = mw; funct3 = f3; Alu_Result = a; Store_Data = sd;
        mem_ready = 1'b0; mem_rdata = rd;
        @(negedge clk);
        n_checks++;
        if (misaligned !== bad) begin
            n_fail++; $display("FAIL %s misaligned: got %b want %b", nm, misaligned, bad);
        end
        n_checks++;
        if (stall !== !bad || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL %s launch: stall=%b req=%b want stall=%b req=0", nm, stall, mem_req, !bad);
        end
        if (bad) begin
            @(posedge clk); #1; MemRead = 0; MemWrite = 0;
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b0 || MemReadData !== model_rd) begin
                n_fail++; $display("FAIL %s misaligned_after: req=%b rd=%h want req=0 rd=%h", nm, mem_req, MemReadData, model_rd);
            end
            $display("txn %s misaligned addr=%h", nm, a);
            return;
        end
        stall_cnt = 1;
        for (int c = 0; c < TO + 4; c++) begin
            @(posedge clk); #1;
            mem_ready = (wait_cyc == waits);
            mem_rdata = (wait_cyc == waits) ? rd : $urandom;
            @(negedge clk);
            if (!stall) begin
                done_seen = 1'b1;
                break;
            end
            stall_cnt++;
            wait_cyc++;
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== is_st || mem_addr !== (a & ~32'h3) ||
                mem_wstrb !== e_strb || (is_st && mem_wdata !== e_wdata)) begin
                n_fail++;
                $display("FAIL %s bus: req=%b we=%b addr=%h strb=%b wdata=%h want 1 %b %h %b %h",
                         nm, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
                         is_st, a & ~32'h3, e_strb, e_wdata);
            end
        end
        n_checks++;
        if (!done_seen) begin
            n_fail++; $display("FAIL %s no_done: stall still high after %0d cycles, want release", nm, stall_cnt);
        end
        if (tmo)        e_rd = 32'h0;
        else if (is_st) e_rd = model_rd;
        else            e_rd = exp_load(f3, a, rd);
        model_rd = e_rd;
        n_checks++;
        if (stall_cnt != exp_wait + 1 || wait_cyc != exp_wait) begin
            n_fail++; $display("FAIL %s latency: stall=%0d req=%0d want stall=%0d req=%0d", nm, stall_cnt, wait_cyc, exp_wait + 1, exp_wait);
        end
        n_checks++;
        if (mem_req !== 1'b0 || bus_err !== tmo || MemReadData !== e_rd) begin
            n_fail++; $display("FAIL %s done: req=%b err=%b rd=%h want req=0 err=%b rd=%h", nm, mem_req, bus_err, MemReadData, tmo, e_rd);
        end
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0; mem_ready = 0;
        @(negedge clk);
        n_checks++;
        if (bus_err !== 1'b0 || stall !== 1'b0 || MemReadData !== e_rd) begin
            n_fail++; $display("FAIL %s after: err=%b stall=%b rd=%h want 0 0 %h", nm, bus_err, stall, MemReadData, e_rd);
        end
        $display("txn %s mr=%b mw=%b f3=%0d addr=%h waits=%0d rd=%h err=%b", nm, mr, mw, f3, a, waits, MemReadData, tmo);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, MemReadData, bus_err, stall} !== '0) begin
            n_fail++; $display("FAIL reset_state: req=%b we=%b addr=%h wd=%h st=%b rd=%h err=%b stall=%b want all 0",
                               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, MemReadData, bus_err, stall);
        end
        reset = 1'b0;
        model_rd = 32'h0;
        $display("txn reset done");
    endtask

    task automatic test_directed();
        do_txn("lw_zero_wait", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        do_txn("lb_sign",      1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);
        do_txn("lbu",          1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1);
        do_txn("lhu",          1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0);
        do_txn("sh_3wait",     0, 1, 3'b001, 32'h206, 32'h0000ABCD, 32'h0, 3);
        do_txn("sb_lane1",     0, 1, 3'b000, 32'h301, 32'h123456A5, 32'h0, 0);
        do_txn("both_is_store",1, 1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h11111111, 1);
        do_txn("lw_misalign",  1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        do_txn("lh_misalign",  1, 0, 3'b001, 32'h103, 32'h0, 32'h0, 0);
        do_txn("lw_timeout",   1, 0, 3'b010, 32'h500, 32'h0, 32'h12345678, TO + 10);
        do_txn("lh_after_to",  1, 0, 3'b001, 32'h502, 32'h0, 32'h9ABC0000, 2);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        MemRead = 1; MemWrite = 0; funct3 = 3'b010; Alu_Result = 32'h600; mem_ready = 0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: req=%b want 1", mem_req);
        end
        #1; reset = 1'b1; MemRead = 0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_async: req=%b stall=%b want 0 0", mem_req, stall);
        end
        @(posedge clk); #1; reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFEEDFACE;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(negedge clk);
        model_rd = 32'h0;
        n_checks++;
        if (MemReadData !== 32'h0 || mem_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_after: rd=%h req=%b stall=%b err=%b want 0", MemReadData, mem_req, stall, bus_err);
        end
        $display("txn reset_mid done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int sel = $urandom_range(0, 2);
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] a  = 32'($urandom_range(0, 4095));
            do_txn($sformatf("rnd%0d", i), sel != 1, sel != 0, f3, a, $urandom, $urandom,
                   $urandom_range(0, TO + 1));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1; mem_ready = 1'b1;
                @(posedge clk); #1; mem_ready = 1'b0;
                @(negedge clk);
                n_checks++;
                if (mem_req !== 1'b0 || MemReadData !== model_rd) begin
                    n_fail++; $display("FAIL rnd_idle_ready: req=%b rd=%h want 0 %h", mem_req, MemReadData, model_rd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
